// File: rtl/adc_spi_pkg.sv
// Shared types and field positions for the ADC configuration-port SPI master.
package adc_spi_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_t;

  localparam int FRAME_BITS = 24;
  localparam int INSTR_BITS = 16;

  localparam int STS_BUSY = 31;
  localparam int STS_DONE = 30;
  localparam int STS_OVR  = 29;

  localparam int CMD_GO = 31;
  localparam int CMD_RW = 23;
endpackage

// File: rtl/adc_spi_tick.sv
// Half-period tick generator: pulses once every CLK_DIV cycles while enabled.
module adc_spi_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic en,
  output logic tick
);
  logic [7:0] cnt;

  assign tick = en && (cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (!reset)
      cnt <= 8'(CLK_DIV - 1);
    else if (restart || !en || cnt == 8'd0)
      cnt <= 8'(CLK_DIV - 1);
    else
      cnt <= cnt - 8'd1;
  end
endmodule

// File: rtl/adc_spi_ctrl.sv
// SPI master for the ADC config port: one 24-bit frame per GO rising edge.
// Optional pad turnaround and read capture under ADC_SPI_READBACK_EN.
module adc_spi_ctrl
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd,
  output logic [31:0] status,
  output logic        adc_csb,
  output logic        adc_sclk,
  output logic        adc_sdo,
  input  logic        adc_sdi,
  output logic        adc_sdio_oe
);
  state_t                  state;
  logic                    go_q, phase, tick, done, ovr;
  logic [4:0]              bit_cnt;
  logic [FRAME_BITS-1:0]   sr;
  logic [INSTR_BITS-1:0]   echo;
  logic [7:0]              rdata;
  logic                    start_edge;

  assign start_edge = cmd[CMD_GO] && !go_q;

  adc_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (start_edge && state == ST_IDLE),
    .en      (state != ST_IDLE),
    .tick    (tick)
  );

`ifdef ADC_SPI_READBACK_EN
  logic rw, cap;
  // Pad is released once the last instruction bit has been clocked out.
  logic rd_phase;
  assign rd_phase = rw && ((state == ST_SHIFT && bit_cnt < 5'd8) || state == ST_HOLD);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rw          <= 1'b0;
      cap         <= 1'b0;
      rdata       <= 8'd0;
      adc_sdio_oe <= 1'b1;
    end else begin
      if (state == ST_IDLE && start_edge)
        rw <= cmd[CMD_RW];
      // Sample on the edge where SCLK actually falls, one cycle after the tick.
      cap <= rw && state == ST_SHIFT && tick && phase && bit_cnt < 5'd8;
      if (cap)
        rdata <= {rdata[6:0], adc_sdi};
      adc_sdio_oe <= !rd_phase;
    end
  end
`else
  logic unused_sdi;
  assign unused_sdi  = adc_sdi;
  assign rdata       = 8'd0;
  assign adc_sdio_oe = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      go_q     <= 1'b1;
      phase    <= 1'b0;
      bit_cnt  <= 5'd0;
      sr       <= '0;
      echo     <= '0;
      done     <= 1'b0;
      ovr      <= 1'b0;
      adc_csb  <= 1'b1;
      adc_sclk <= 1'b0;
      adc_sdo  <= 1'b0;
      status   <= 32'd0;
    end else begin
      go_q <= cmd[CMD_GO];
      if (start_edge && state != ST_IDLE)
        ovr <= 1'b1;
      case (state)
        ST_IDLE: if (start_edge) begin
          sr    <= cmd[FRAME_BITS-1:0];
          echo  <= cmd[23:8];
          done  <= 1'b0;
          ovr   <= 1'b0;
          state <= ST_SETUP;
        end
        ST_SETUP: if (tick) begin
          state   <= ST_SHIFT;
          phase   <= 1'b0;
          bit_cnt <= 5'd23;
        end
        ST_SHIFT: if (tick) begin
          if (!phase)
            phase <= 1'b1;
          else begin
            phase <= 1'b0;
            sr    <= {sr[FRAME_BITS-2:0], 1'b0};
            if (bit_cnt == 5'd0) state <= ST_HOLD;
            else bit_cnt <= bit_cnt - 5'd1;
          end
        end
        ST_HOLD: if (tick) begin
          state <= ST_GAP;
          phase <= 1'b0;
        end
        ST_GAP: if (tick) begin
          if (!phase)
            phase <= 1'b1;
          else begin
            phase <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Outputs follow the internal state by one edge.
      adc_csb  <= !(state == ST_SETUP || state == ST_SHIFT || state == ST_HOLD);
      adc_sclk <= state == ST_SHIFT && phase;
      adc_sdo  <= state == ST_SHIFT && sr[FRAME_BITS-1];
      status   <= {state != ST_IDLE, done, ovr, 5'd0, echo, rdata};
    end
  end
endmodule

// File: tb/tb_adc_spi_ctrl.sv
// Directed bench for adc_spi_ctrl: write, read, overrun, held GO, mid-frame reset, CLK_DIV=2.
module tb_adc_spi_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cmd, cmd2;
  logic [31:0] status, status2;
  logic        adc_csb, adc_sclk, adc_sdo, adc_sdi, adc_sdio_oe;
  logic        csb2, sclk2, sdo2, oe2;

  int errs = 0, checks = 0;

`ifdef ADC_SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  always #5 clk = ~clk;

  adc_spi_ctrl #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .status(status),
    .adc_csb(adc_csb), .adc_sclk(adc_sclk), .adc_sdo(adc_sdo),
    .adc_sdi(adc_sdi), .adc_sdio_oe(adc_sdio_oe)
  );

  adc_spi_ctrl #(.CLK_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .cmd(cmd2), .status(status2),
    .adc_csb(csb2), .adc_sclk(sclk2), .adc_sdo(sdo2),
    .adc_sdi(1'b0), .adc_sdio_oe(oe2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int          busy_n, csb_n, rises, oe_low, oe_first;
  logic [23:0] bits;

  // Runs one frame on dut, sampling on the falling clk edge; ADC model drives rd on bits 7..0.
  task automatic run_frame(input logic [31:0] c, input logic [7:0] rd, input int tog);
    logic prev_sclk, seen;
    busy_n = 0; csb_n = 0; rises = 0; oe_low = 0; oe_first = -1; bits = '0;
    prev_sclk = 1'b0; seen = 1'b0;
    cmd = c;
    for (int i = 0; i < 600; i++) begin
      if (tog >= 0 && i == tog - 10) cmd[31] = 1'b0;
      if (tog >= 0 && i == tog) cmd[31] = 1'b1;
      @(negedge clk);
      if (status[31]) begin busy_n++; seen = 1'b1; end
      if (!adc_csb) csb_n++;
      if (adc_sclk && !prev_sclk) begin
        rises++;
        bits = {bits[22:0], adc_sdo};
      end
      if (!adc_sdio_oe) begin
        oe_low++;
        if (oe_first < 0) oe_first = rises;
      end
      prev_sclk = adc_sclk;
      adc_sdi = (rises >= 17 && rises <= 24) ? rd[24 - rises] : 1'b0;
      if (seen && !status[31]) break;
    end
  endtask

  initial begin
    logic [7:0] exp_rd;
    int cnt, cnt2;
    reset = 1'b0; cmd = '0; cmd2 = '0; adc_sdi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_csb",    32'(adc_csb), 32'd1);
    chk("rst_sclk",   32'(adc_sclk), 32'd0);
    chk("rst_sdo",    32'(adc_sdo), 32'd0);
    chk("rst_oe",     32'(adc_sdio_oe), 32'd1);
    chk("rst_status", status, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Write frame
    run_frame(32'h80000A5C, 8'h00, -1);
    chk("wr_busy",   32'(busy_n), 32'd208);
    chk("wr_csb",    32'(csb_n), 32'd200);
    chk("wr_rises",  32'(rises), 32'd24);
    chk("wr_bits",   32'(bits), 32'h000A5C);
    chk("wr_oe",     32'(oe_low), 32'd0);
    chk("wr_status", status, 32'h40000A00);

    // Read frame
    cmd = '0; repeat (2) @(negedge clk);
    run_frame(32'h80800100, 8'hA7, -1);
    exp_rd = RB ? 8'hA7 : 8'h00;
    chk("rd_busy",     32'(busy_n), 32'd208);
    chk("rd_rises",    32'(rises), 32'd24);
    chk("rd_oe_low",   32'(oe_low), RB ? 32'd68 : 32'd0);
    chk("rd_oe_first", 32'(oe_first), RB ? 32'd16 : 32'hFFFF_FFFF);
    chk("rd_status",   status, {16'h4080, 8'h01, exp_rd});

    // Overrun: GO re-toggled mid-frame
    cmd = '0; repeat (2) @(negedge clk);
    run_frame(32'h80001234, 8'h00, 50);
    chk("ov_busy",   32'(busy_n), 32'd208);
    chk("ov_bits",   32'(bits), 32'h001234);
    chk("ov_status", status, {16'h6000, 8'h12, exp_rd});
    cmd = '0; repeat (2) @(negedge clk);
    run_frame(32'h80000A5C, 8'h00, -1);
    chk("ov_clear", status, {16'h4000, 8'h0A, exp_rd});

    // Held GO: exactly one frame
    cmd = '0; repeat (2) @(negedge clk);
    run_frame(32'h80000055, 8'h00, -1);
    chk("hold_busy1", 32'(busy_n), 32'd208);
    cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (status[31] || !adc_csb) cnt++;
    end
    chk("hold_nobusy", 32'(cnt), 32'd0);
    chk("hold_status", status, {24'h400000, exp_rd});

    // Reset in the middle of SHIFT bit 12
    cmd = '0; repeat (2) @(negedge clk);
    cmd = 32'h80000A5C;
    begin
      logic p;
      p = 1'b0; cnt = 0;
      for (int i = 0; i < 400 && cnt < 12; i++) begin
        @(negedge clk);
        if (adc_sclk && !p) cnt++;
        p = adc_sclk;
      end
    end
    chk("mid_rises", 32'(cnt), 32'd12);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_csb",    32'(adc_csb), 32'd1);
    chk("mid_sclk",   32'(adc_sclk), 32'd0);
    chk("mid_status", status, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (status[31] || !adc_csb) cnt++;
    end
    chk("mid_nostart", 32'(cnt), 32'd0);

    // CLK_DIV=2 instance
    cmd2 = 32'h80000A5C;
    cnt = 0; cnt2 = 0;
    begin
      logic p;
      p = 1'b0;
      repeat (300) begin
        @(negedge clk);
        if (status2[31]) cnt++;
        if (sclk2 && !p) cnt2++;
        p = sclk2;
      end
    end
    chk("div2_busy",   32'(cnt), 32'd104);
    chk("div2_rises",  32'(cnt2), 32'd24);
    chk("div2_status", status2, 32'h40000A00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/adc_spi_ctrl.md
# adc_spi_ctrl

Serial-programming master for the ADC's configuration port, sitting directly downstream of the general register block. It consumes the 32-bit command word written into register 0 (`adc_intf_data_out`) and produces the 32-bit status word that register 1 samples every cycle (`adc_intf_data_in`). A rising edge of the command's GO bit launches one 24-bit SPI frame (16-bit instruction plus 8-bit data) to the ADC; for read frames the returned byte is captured into the status word.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; legal range 2..255.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  reset, synchronous and active-low; all state is cleared on a `clk` edge while `reset`=0.
- `cmd`  in  32  command word from register 0. Fields:
  - [31] GO
  - [23] R/W (1=read)
  - [23:8] instruction
  - [7:0] write data
  - [30:24] ignored
- `status`  out  32  status word to register 1. Fields:
  - [31] BUSY
  - [30] DONE
  - [29] OVERRUN
  - [28:24] 0
  - [23:8] echo of the instruction of the last accepted frame
  - [7:0] RDATA
- `adc_csb`  out  1  ADC chip select, active-low.
- `adc_sclk`  out  1  SPI clock; idles low.
- `adc_sdo`  out  1  master data out, MSB first.
- `adc_sdi`  in  1  ADC data in, already synchronised externally.
- `adc_sdio_oe`  out  1  output enable for the external SDIO pad buffer (1=drive).

## Operation
- Start detect: `go_q` registers `cmd[31]`. A start is accepted when `cmd[31]`=1, `go_q`=0 and the state is IDLE.
- Start edge while not IDLE: ignored; sets OVERRUN.
- Accepted start:
  - latches `cmd[23:0]` into the shift register;
  - clears DONE and OVERRUN;
  - loads the status echo field.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  - SETUP: CSB low, SCLK low, for CLK_DIV cycles.
  - SHIFT: 24 bits. Each bit has SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles. `adc_sdo` changes only at the start of the low phase.
  - HOLD: SCLK low, CSB still low, for CLK_DIV cycles.
  - GAP: CSB high, for 2×CLK_DIV cycles. This enforces the minimum CSB-high time.
- Bit counter: 5 bits, counts 23 down to 0. SHIFT exits after the high phase of bit 0.
- Read frames (R/W=1):
  - `adc_sdio_oe`=0 from the falling SCLK edge that ends bit 8 (the last instruction bit) to the end of the frame.
  - `adc_sdi` is sampled on the `clk` edge that ends each high phase of bits 7..0, shifted MSB first into RDATA.
- Write frames: `adc_sdio_oe`=1 for the whole frame; RDATA is held unchanged.
- End of GAP: BUSY falls and DONE rises in the same cycle. DONE stays set until the next accepted start.
- Reset values: `adc_csb`=1, `adc_sclk`=0, `adc_sdo`=0, `adc_sdio_oe`=1, `status`=0, state IDLE, `go_q`=1.
  - `go_q` resets to 1 so a GO bit already high when reset releases does not launch a frame.
- Reset asserted mid-frame: the frame aborts on that edge. All outputs take their reset values and no DONE is produced.

## Timing
- Accepted start at edge N: CSB low and BUSY=1 from edge N+1.
- First SCLK rise at N+1+2×CLK_DIV.
- Frame length: BUSY is high for 4×CLK_DIV + 48×CLK_DIV cycles. For CLK_DIV=4 that is 208 cycles, with exactly 24 SCLK rising edges.
- `status` is registered: it changes one edge after the internal event.
- Register 1 adds one further cycle before software sees the change.
- GO held high indefinitely: exactly one frame. A new frame needs GO to go 0 then 1; the earliest restart is the edge after IDLE is re-entered.

## Configuration
- `ADC_SPI_READBACK_EN` defined:
  - read frames turn the pad around and capture RDATA as described above.
- `ADC_SPI_READBACK_EN` undefined:
  - `adc_sdio_oe` is tied to 1;
  - `adc_sdi` is unused;
  - RDATA is constant 0;
  - read frames shift all 24 bits out as writes;
  - frame timing is identical.

## Structure
- Package `adc_spi_pkg` holds:
  - state enum;
  - `FRAME_BITS`=24, `INSTR_BITS`=16;
  - status bit positions BUSY=31, DONE=30, OVERRUN=29;
  - cmd bit positions GO=31, RW=23.
- Sub-module `adc_spi_tick`:
  - a CLK_DIV down-counter that emits a one-cycle half-period tick;
  - restarts on frame start;
  - held cleared in IDLE.

## Test plan
- Write: reset, then `cmd`=0x80000A5C. Expect:
  - CSB low for 200 cycles;
  - SDO bit stream 0x000A5C MSB first;
  - 24 SCLK rises;
  - `status`=0x40000A00 after the frame;
  - `adc_sdio_oe`=1 throughout.
- Read: `cmd`=0x80800100, ADC model drives 0xA7 on bits 7..0. Expect:
  - `adc_sdio_oe` low from the end of bit 8;
  - `status`=0x408001A7.
- Overrun: GO toggled 0→1 at cycle 50 of an active frame. Expect:
  - frame unaffected;
  - after completion `status`[30:29]=11;
  - the next accepted start clears bit 29.
- Held GO: GO held at 1 for 1000 cycles. Expect exactly one frame; BUSY never re-asserts.
- Reset mid-frame: `reset`=0 at SHIFT bit 12. Expect:
  - next edge `adc_csb`=1, `adc_sclk`=0, `status`=0;
  - GO still high after release starts no frame.
- CLK_DIV=2 build: write frame. Expect BUSY high for exactly 104 cycles.
